soc_msp430_irq_ctrl: RTL and testbench



---
 rtl/soc_msp430_irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_soc_msp430_irq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_msp430_irq_ctrl.sv
// Interrupt aggregator for the MSP430 peripheral bus.
// Collects NUM_SRC synchronised sources behind one vector with a clear-on-read IV register.
module soc_msp430_irq_ctrl #(
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [14:0] BASE_ADDR   = 15'h0140
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic [13:0]        per_addr,
  input  logic [15:0]        per_din,
  input  logic               per_en,
  input  logic [1:0]         per_we,
  output logic [15:0]        per_dout,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq_out,
  output logic [4:0]         iv_out
);

  localparam logic [15:0] VALID =
    16'((17'd1 << NUM_SRC) - 17'd1);
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][15:0] sync_q, sync_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] ifg_q, ifg_d;
  logic [15:0] ie_q, ie_d;
  logic [15:0] ies_q, ies_d;
  logic [15:0] mode_q, mode_d;
  logic [2:0]  arm_q, arm_d;

  logic        sel, rd, wr;
  logic [2:0]  off;
  logic [15:0] lane, wbits;
  logic [15:0] s_sync, lvl, evt;
  logic [15:0] ifg_vis, act, first_oh;
  logic [15:0] w1c, set_w, iv_clr;
  logic [5:0]  iv;
  logic        armed;

  assign sel   = per_en & (per_addr[13:3] == BASE_ADDR[14:4]);
  assign off   = per_addr[2:0];
  assign rd    = sel & (per_we == 2'b00);
  assign wr    = sel & (per_we != 2'b00);
  assign lane  = {{8{per_we[1]}}, {8{per_we[0]}}};
  assign wbits = per_din & lane & VALID;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_q == ARM_MAX);

  // Level-mode bits never use the stored flag; they show the live input.
  assign lvl     = s_sync ^ ies_q;
  assign ifg_vis = (ifg_q & ~mode_q) | (lvl & mode_q);
  assign act     = ifg_vis & ie_q;

  always_comb begin
    sync_d[0] = 16'(src) & VALID;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = s_sync;
  end

  always_comb begin
    evt = '0;
    if (armed) begin
      evt = ~mode_q & ((s_sync & ~prev_q & ~ies_q) |
                       (~s_sync & prev_q & ies_q));
    end
  end

  // Downward scan so the lowest active index wins.
  always_comb begin
    iv       = '0;
    first_oh = '0;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) begin
        iv       = 6'((i + 1) * 2);
        first_oh = '0;
        first_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w1c    = (wr && off == 3'd0) ? wbits : '0;
    set_w  = (wr && off == 3'd5) ? (wbits & ~mode_q) : '0;
    iv_clr = (rd && off == 3'd4) ? (first_oh & ~mode_q) : '0;
    // Set wins over any clear in the same cycle.
    ifg_d  = ((ifg_q & ~w1c & ~iv_clr) | evt | set_w) & ~mode_q;
  end

  always_comb begin
    ie_d   = ie_q;
    ies_d  = ies_q;
    mode_d = mode_q;
    if (wr && off == 3'd1) ie_d   = (ie_q & ~lane) | wbits;
    if (wr && off == 3'd2) ies_d  = (ies_q & ~lane) | wbits;
    if (wr && off == 3'd3) mode_d = (mode_q & ~lane) | wbits;
    arm_d = armed ? arm_q : arm_q + 3'd1;
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      ifg_q  <= '0;
      ie_q   <= '0;
      ies_q  <= '0;
      mode_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      ifg_q  <= ifg_d;
      ie_q   <= ie_d;
      ies_q  <= ies_d;
      mode_q <= mode_d;
      arm_q  <= arm_d;
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (rd) begin
      case (off)
        3'd0:    per_dout = ifg_vis;
        3'd1:    per_dout = ie_q;
        3'd2:    per_dout = ies_q;
        3'd3:    per_dout = mode_q;
        3'd4:    per_dout = 16'(iv);
        default: per_dout = 16'h0000;
      endcase
    end
  end

  assign irq_out = |act;
  assign iv_out  = iv[4:0];

endmodule

// File: tb/tb_soc_msp430_irq_ctrl.sv
// Directed bench for soc_msp430_irq_ctrl.
// Register vector table plus hand-written timing sequences.
module tb_soc_msp430_irq_ctrl;

  localparam logic [13:0] BASE_W = 14'h00A0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [7:0]  src;
  logic        irq_out;
  logic [4:0]  iv_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  woff;
    logic [1:0]  we;
    logic [15:0] din;
    logic [2:0]  roff;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  soc_msp430_irq_ctrl #(
    .NUM_SRC(8), .SYNC_STAGES(2), .BASE_ADDR(15'h0140)
  ) dut (
    .mclk(clk), .reset_n(reset_n), .per_addr(per_addr),
    .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout), .src(src), .irq_out(irq_out),
    .iv_out(iv_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] off,
                        input logic [1:0] we,
                        input logic [15:0] din);
    per_en   = 1'b1;
    per_addr = BASE_W | 14'(off);
    per_we   = we;
    per_din  = din;
    tick();
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic bus_rd(input string name,
                        input logic [2:0] off,
                        input logic [15:0] exp);
    per_en   = 1'b1;
    per_addr = BASE_W | 14'(off);
    per_we   = 2'b00;
    #1;
    check(name, per_dout, exp);
    tick();
    per_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 2'b11, 16'hFFFF, 3'd1, 16'h00FF};
    vecs[1]  = '{3'd1, 2'b11, 16'h0000, 3'd1, 16'h0000};
    vecs[2]  = '{3'd1, 2'b10, 16'hFFFF, 3'd1, 16'h0000};
    vecs[3]  = '{3'd1, 2'b01, 16'h0F0F, 3'd1, 16'h000F};
    vecs[4]  = '{3'd1, 2'b01, 16'h00F0, 3'd1, 16'h00F0};
    vecs[5]  = '{3'd2, 2'b11, 16'h12A5, 3'd2, 16'h00A5};
    vecs[6]  = '{3'd2, 2'b11, 16'h0000, 3'd2, 16'h0000};
    vecs[7]  = '{3'd3, 2'b11, 16'hFFC0, 3'd3, 16'h00C0};
    vecs[8]  = '{3'd3, 2'b11, 16'h0000, 3'd3, 16'h0000};
    vecs[9]  = '{3'd6, 2'b11, 16'hFFFF, 3'd6, 16'h0000};
    vecs[10] = '{3'd7, 2'b11, 16'hFFFF, 3'd7, 16'h0000};
    vecs[11] = '{3'd1, 2'b11, 16'h0000, 3'd0, 16'h0000};

    reset_n  = 1'b0;
    per_addr = '0;
    per_din  = '0;
    per_en   = 1'b0;
    per_we   = 2'b00;
    src      = 8'h04;

    // Source held through reset must not raise a flag
    repeat (10) tick();
    check("rst_irq", {15'b0, irq_out}, 16'h0000);
    check("rst_iv", {11'b0, iv_out}, 16'h0000);
    bus_rd("rst_ifg", 3'd0, 16'h0000);
    reset_n = 1'b1;
    repeat (10) tick();
    bus_rd("arm_ifg", 3'd0, 16'h0000);
    src = 8'h00;
    repeat (5) tick();
    src = 8'h04;
    tick();
    tick();
    bus_rd("lat_e2", 3'd0, 16'h0000);
    bus_rd("lat_e3", 3'd0, 16'h0004);
    bus_wr(3'd0, 2'b11, 16'h0004);
    bus_rd("w1c_ifg", 3'd0, 16'h0000);
    src = 8'h00;
    repeat (4) tick();

    for (int i = 0; i < 12; i++) begin
      bus_wr(vecs[i].woff, vecs[i].we, vecs[i].din);
      bus_rd($sformatf("vec%0d", i), vecs[i].roff, vecs[i].exp);
    end

    // Two edge events, drained through IV reads
    bus_wr(3'd1, 2'b11, 16'h00FF);
    src = 8'h22;
    tick();
    tick();
    src = 8'h00;
    repeat (4) tick();
    check("two_irq", {15'b0, irq_out}, 16'h0001);
    check("two_ivo", {11'b0, iv_out}, 16'h0004);
    bus_rd("two_ifg", 3'd0, 16'h0022);
    bus_rd("iv_rd1", 3'd4, 16'h0004);
    bus_rd("iv_rd2", 3'd4, 16'h000C);
    check("iv_irq0", {15'b0, irq_out}, 16'h0000);
    bus_rd("iv_rd3", 3'd4, 16'h0000);
    bus_rd("iv_ifg0", 3'd0, 16'h0000);

    // Active-low level source
    bus_wr(3'd2, 2'b11, 16'h0008);
    bus_wr(3'd3, 2'b11, 16'h0008);
    bus_wr(3'd1, 2'b11, 16'h0008);
    check("lvl_irq1", {15'b0, irq_out}, 16'h0001);
    bus_rd("lvl_ifg", 3'd0, 16'h0008);
    bus_wr(3'd0, 2'b11, 16'h0008);
    bus_rd("lvl_w1c", 3'd0, 16'h0008);
    bus_rd("lvl_iv1", 3'd4, 16'h0008);
    bus_rd("lvl_iv2", 3'd4, 16'h0008);
    src = 8'h08;
    repeat (3) tick();
    check("lvl_irq0", {15'b0, irq_out}, 16'h0000);
    bus_rd("lvl_ifg0", 3'd0, 16'h0000);
    bus_wr(3'd3, 2'b11, 16'h0000);
    bus_rd("edge_back", 3'd0, 16'h0000);
    src = 8'h00;
    tick();
    tick();
    bus_rd("fall_e2", 3'd0, 16'h0000);
    bus_rd("fall_e3", 3'd0, 16'h0008);
    bus_wr(3'd2, 2'b11, 16'h0000);
    bus_wr(3'd0, 2'b11, 16'h0008);
    bus_rd("fall_clr", 3'd0, 16'h0000);

    // Event landing on the same edge as W1C
    bus_wr(3'd1, 2'b11, 16'h0001);
    src = 8'h01;
    tick();
    tick();
    src = 8'h00;
    repeat (4) tick();
    bus_rd("pre_ifg", 3'd0, 16'h0001);
    src = 8'h01;
    tick();
    tick();
    bus_wr(3'd0, 2'b11, 16'h0001);
    bus_rd("set_win", 3'd0, 16'h0001);
    bus_wr(3'd0, 2'b11, 16'h0001);
    bus_rd("w1c_only", 3'd0, 16'h0000);
    src = 8'h00;
    repeat (4) tick();

    // Unselected accesses read zero
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = 14'h00B1;
    #1;
    check("nosel_addr", per_dout, 16'h0000);
    per_en   = 1'b0;
    per_addr = BASE_W | 14'd1;
    #1;
    check("nosel_en", per_dout, 16'h0000);
    tick();

    // SET, then reset during an IV read
    bus_wr(3'd2, 2'b11, 16'h00FF);
    bus_wr(3'd3, 2'b11, 16'h000F);
    bus_wr(3'd1, 2'b11, 16'h0010);
    bus_wr(3'd5, 2'b11, 16'h0010);
    check("set_irq", {15'b0, irq_out}, 16'h0001);
    check("set_ivo", {11'b0, iv_out}, 16'h000A);
    bus_rd("set_ifg", 3'd0, 16'h001F);
    per_en   = 1'b1;
    per_addr = BASE_W | 14'd4;
    per_we   = 2'b00;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    per_en  = 1'b0;
    check("post_irq", {15'b0, irq_out}, 16'h0000);
    check("post_ivo", {11'b0, iv_out}, 16'h0000);
    bus_rd("post_ifg", 3'd0, 16'h0000);
    bus_rd("post_ie", 3'd1, 16'h0000);
    bus_rd("post_ies", 3'd2, 16'h0000);
    bus_rd("post_mode", 3'd3, 16'h0000);
    bus_rd("post_iv", 3'd4, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
